// File: rtl/por_status_reporter.sv
// Dual power-on-reset monitor: synchronize, debounce, sequence-check and
// queue state-change events for a consumer.
module por_status_reporter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [3:0]  CODE_ONE        = 4'h9,
  parameter logic [3:0]  CODE_BOTH       = 4'h5
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       por1_raw,
  input  logic       por2_raw,
  output logic [1:0] status,
  output logic [3:0] checkbits,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ack,
  output logic       fault,
  output logic       evt_overflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONE   = 3'd1,
    BOTH  = 3'd2,
    FAULT = 3'd3
  } state_e;

  localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] lvl_q, lvl_d;
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];

  state_e     state_q, state_d;
  logic [1:0] status_q, status_d;
  logic [3:0] cb_q, cb_d;
  logic       fault_q, fault_d;

  logic [2:0] mem_q [4];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       push, pop, full, wr_en;

  logic d1, d2;
  assign d1 = lvl_q[0];
  assign d2 = lvl_q[1];

  // Counter only runs while the synchronized sample disagrees with the level
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d1 && d2)  state_d = BOTH;
        else if (d1)   state_d = ONE;
        else if (d2)   state_d = FAULT;
      end
      ONE: begin
        if (d2)        state_d = BOTH;
        else if (!d1)  state_d = IDLE;
      end
      BOTH: begin
        if (!d1)       state_d = FAULT;
        else if (!d2)  state_d = ONE;
      end
      FAULT: begin
        if (!d1 && !d2) state_d = IDLE;
      end
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d = 2'b00;
    cb_d     = 4'h0;
    unique case (state_d)
      IDLE: begin
        status_d = 2'b00;
        cb_d     = 4'h0;
      end
      ONE: begin
        status_d = 2'b01;
        cb_d     = CODE_ONE;
      end
      BOTH: begin
        status_d = 2'b11;
        cb_d     = CODE_BOTH;
      end
      FAULT: begin
        status_d = {d2, d1};
        cb_d     = 4'hF;
      end
      default: begin
        status_d = 2'b00;
        cb_d     = 4'h0;
      end
    endcase
    fault_d = fault_q | ((state_d == FAULT) && (state_q != FAULT));
  end

  // A pop frees a slot in the same edge, so full+push+pop is not an overflow
  always_comb begin
    push    = (state_d != state_q);
    pop     = evt_valid & evt_ack;
    full    = (count_q == 3'd4);
    wr_en   = push & (~full | pop);
    wr_d    = wr_en ? wr_q + 2'd1 : wr_q;
    rd_d    = pop ? rd_q + 2'd1 : rd_q;
    count_d = 3'(count_q + {2'b00, wr_en} - {2'b00, pop});
    ovf_d   = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      lvl_q    <= 2'b00;
      cnt_q[0] <= 8'd0;
      cnt_q[1] <= 8'd0;
      state_q  <= IDLE;
      status_q <= 2'b00;
      cb_q     <= 4'h0;
      fault_q  <= 1'b0;
      wr_q     <= 2'd0;
      rd_q     <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= {por2_raw, por1_raw};
      sync2_q  <= sync1_q;
      lvl_q    <= lvl_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      state_q  <= state_d;
      status_q <= status_d;
      cb_q     <= cb_d;
      fault_q  <= fault_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (resetb && wr_en) begin
      mem_q[wr_q] <= state_d;
    end
  end

  assign status       = status_q;
  assign checkbits    = cb_q;
  assign fault        = fault_q;
  assign evt_overflow = ovf_q;
  assign evt_valid    = (count_q != 3'd0);
  assign evt_code     = evt_valid ? mem_q[rd_q] : 3'd0;

endmodule

// File: tb/tb_por_status_reporter.sv
// Bench for por_status_reporter: directed table, corner sequences and
// random stimulus against a cycle-level reference model.
module tb_por_status_reporter;

  localparam int DEB = 16;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       por1_raw = 1'b0;
  logic       por2_raw = 1'b0;
  logic       evt_ack = 1'b0;
  logic [1:0] status;
  logic [3:0] checkbits;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       fault;
  logic       evt_overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  por_status_reporter #(
    .DEBOUNCE_CYCLES(DEB),
    .CODE_ONE(4'h9),
    .CODE_BOTH(4'h5)
  ) dut (
    .clock(clock),
    .resetb(resetb),
    .por1_raw(por1_raw),
    .por2_raw(por2_raw),
    .status(status),
    .checkbits(checkbits),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_ack(evt_ack),
    .fault(fault),
    .evt_overflow(evt_overflow)
  );

  // Reference model: pipeline delays, run-length debounce, table FSM, queue
  int         m_s1 [2];
  int         m_s2 [2];
  int         m_lvl [2];
  int         m_run [2];
  int         m_state;
  logic [1:0] m_status;
  logic [3:0] m_cb;
  bit         m_fault;
  bit         m_ovf;
  int         m_q [$];

  function automatic int next_state(int s, int d1, int d2);
    case (s)
      0: if (d1 && d2) return 2;
         else if (d1) return 1;
         else if (d2) return 3;
         else return 0;
      1: if (d2) return 2;
         else if (!d1) return 0;
         else return 1;
      2: if (!d1) return 3;
         else if (!d2) return 1;
         else return 2;
      default: if (!d1 && !d2) return 0;
               else return 3;
    endcase
  endfunction

  function automatic void model_edge();
    int ns;
    int raw [2];
    raw[0] = int'(por1_raw);
    raw[1] = int'(por2_raw);
    if (!resetb) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      end
      m_state = 0; m_status = 2'b00; m_cb = 4'h0;
      m_fault = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    ns = next_state(m_state, m_lvl[0], m_lvl[1]);
    if (m_q.size() > 0 && evt_ack) void'(m_q.pop_front());
    if (ns != m_state) begin
      if (m_q.size() < 4) m_q.push_back(ns);
      else m_ovf = 1;
    end
    if (ns == 3 && m_state != 3) m_fault = 1;
    case (ns)
      0: begin m_status = 2'b00; m_cb = 4'h0; end
      1: begin m_status = 2'b01; m_cb = 4'h9; end
      2: begin m_status = 2'b11; m_cb = 4'h5; end
      default: begin
        m_status = {m_lvl[1] != 0, m_lvl[0] != 0};
        m_cb = 4'hF;
      end
    endcase
    m_state = ns;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = 1 - m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [2:0] code;
    @(posedge clock);
    model_edge();
    #1;
    code = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
    chk("model", {20'd0, status, checkbits, evt_valid, evt_code, fault,
                  evt_overflow},
        {20'd0, m_status, m_cb, m_q.size() > 0, code, m_fault, m_ovf});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    por1_raw = 1'b0;
    por2_raw = 1'b0;
    evt_ack = 1'b0;
    run(3);
    resetb = 1'b1;
  endtask

  task automatic pop_expect(input logic [2:0] code);
    chk("evt_valid", 32'(evt_valid), 32'd1);
    chk("evt_code", 32'(evt_code), 32'(code));
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
  endtask

  typedef struct {
    bit         rb;
    bit         p1;
    bit         p2;
    int         cyc;
    logic [1:0] st;
    logic [3:0] cb;
    bit         flt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{0, 0, 0, 2,  2'b00, 4'h0, 0};
    tbl[1] = '{1, 0, 1, 25, 2'b10, 4'hF, 1};
    tbl[2] = '{1, 0, 0, 25, 2'b00, 4'h0, 1};
    tbl[3] = '{0, 0, 0, 2,  2'b00, 4'h0, 0};
    tbl[4] = '{1, 1, 0, 25, 2'b01, 4'h9, 0};
    tbl[5] = '{1, 1, 1, 25, 2'b11, 4'h5, 0};
    tbl[6] = '{1, 0, 1, 25, 2'b10, 4'hF, 1};
    tbl[7] = '{1, 1, 1, 25, 2'b11, 4'hF, 1};
    tbl[8] = '{1, 0, 0, 25, 2'b00, 4'h0, 1};

    model_edge();
    do_reset();
    chk("reset_out", {26'd0, status, checkbits, evt_valid, fault},
        32'd0);
    chk("reset_code", 32'(evt_code), 32'd0);

    foreach (tbl[i]) begin
      resetb = tbl[i].rb;
      por1_raw = tbl[i].p1;
      por2_raw = tbl[i].p2;
      run(tbl[i].cyc);
      chk("tbl_status", 32'(status), 32'(tbl[i].st));
      chk("tbl_check", 32'(checkbits), 32'(tbl[i].cb));
      chk("tbl_fault", 32'(fault), 32'(tbl[i].flt));
    end
    resetb = 1'b1;

    // Power-up order with latency check
    do_reset();
    por1_raw = 1'b1;
    run(18);
    chk("p1_early", 32'(status), 32'd0);
    run(2);
    chk("p1_status", 32'(status), 32'd1);
    chk("p1_check", 32'(checkbits), 32'h9);
    run(180);
    por2_raw = 1'b1;
    run(18);
    chk("p2_early", 32'(status), 32'd1);
    run(2);
    chk("p2_status", 32'(status), 32'd3);
    chk("p2_check", 32'(checkbits), 32'h5);
    pop_expect(3'd1);
    pop_expect(3'd2);
    chk("drained", 32'(evt_valid), 32'd0);

    // Mid-operation reset from BOTH with two events queued
    por2_raw = 1'b0;
    run(25);
    por2_raw = 1'b1;
    run(25);
    chk("pre_rst_status", 32'(status), 32'd3);
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_check", 32'(checkbits), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Short glitch must be filtered
    do_reset();
    por1_raw = 1'b1;
    run(10);
    por1_raw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("glitch", {29'd0, status, evt_valid}, 32'd0);
    end

    // POR2 without POR1
    do_reset();
    por2_raw = 1'b1;
    run(25);
    chk("f_check", 32'(checkbits), 32'hF);
    chk("f_fault", 32'(fault), 32'd1);
    pop_expect(3'd3);
    por2_raw = 1'b0;
    run(25);
    chk("f_idle", 32'(status), 32'd0);
    chk("f_sticky", 32'(fault), 32'd1);
    pop_expect(3'd0);

    // Overflow: fifth event dropped
    do_reset();
    por1_raw = 1'b1; run(25);
    por2_raw = 1'b1; run(25);
    por2_raw = 1'b0; run(25);
    por2_raw = 1'b1; run(25);
    por1_raw = 1'b0; run(25);
    chk("ovf_set", 32'(evt_overflow), 32'd1);
    pop_expect(3'd1);
    pop_expect(3'd2);
    pop_expect(3'd1);
    pop_expect(3'd2);
    chk("ovf_empty", 32'(evt_valid), 32'd0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    por1_raw = 1'b1; run(25);
    por2_raw = 1'b1; run(25);
    por2_raw = 1'b0; run(25);
    por2_raw = 1'b1; run(25);
    por2_raw = 1'b0;
    run(DEB + 2);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    chk("pp_no_ovf", 32'(evt_overflow), 32'd0);
    pop_expect(3'd2);
    pop_expect(3'd1);
    pop_expect(3'd2);
    pop_expect(3'd1);
    chk("pp_empty", 32'(evt_valid), 32'd0);

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) por1_raw = ~por1_raw;
      if ($urandom_range(29) == 0) por2_raw = ~por2_raw;
      evt_ack = ($urandom_range(3) == 0);
      resetb = ($urandom_range(499) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/por_status_reporter.md
POR_STATUS_REPORTER -- requirements
Module: por_status_reporter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16 (range 2..255): consecutive stable synchronized samples required before a POR level change is accepted.
REQ-002 SHALL have parameter CODE_ONE, default 4'h9: checkbits value while only POR1 is good.
REQ-003 SHALL have parameter CODE_BOTH, default 4'h5: checkbits value while both PORs are good.
REQ-004 SHALL have port clock, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port resetb, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port por1_raw, input, 1: first POR power-good, asynchronous, high = good.
REQ-007 SHALL have port por2_raw, input, 1: second POR power-good, asynchronous, high = good.
REQ-008 SHALL have port status, output, 2: {por2_good, por1_good}, the debounced levels as reported by the FSM.
REQ-009 SHALL have port checkbits, output, 4: state code for the pad readback.
REQ-010 SHALL have port evt_valid, output, 1: the event FIFO is non-empty.
REQ-011 SHALL have port evt_code, output, 3: the head-of-FIFO event (new-state encoding).
REQ-012 SHALL have port evt_ack, input, 1: pop request from the consumer.
REQ-013 SHALL have port fault, output, 1: sticky sequencing fault.
REQ-014 SHALL have port evt_overflow, output, 1: sticky FIFO overflow.

Function
REQ-015 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-016 SHALL keep, per input, a debounced level and a counter; the counter SHALL clear whenever the synchronized sample equals the debounced level.
REQ-017 SHALL increment the counter whenever the synchronized sample differs from the debounced level.
REQ-018 SHALL flip the debounced level, and clear the counter, on the edge that sees the DEBOUNCE_CYCLES-th consecutive differing sample.
REQ-019 SHALL allow a pulse shorter than DEBOUNCE_CYCLES synchronized samples to change nothing.
REQ-020 SHALL implement an FSM with states IDLE (code 3'd0), ONE (3'd1), BOTH (3'd2) and FAULT (3'd3), evaluated on the debounced levels (d1, d2).
REQ-021 In IDLE, the FSM SHALL take these transitions:
  - d1 & !d2 -> ONE
  - d1 & d2 (same cycle) -> BOTH
  - !d1 & d2 -> FAULT
REQ-022 In ONE, the FSM SHALL take these transitions:
  - d2 -> BOTH
  - !d1 -> IDLE
REQ-023 In BOTH, the FSM SHALL take these transitions:
  - !d1 -> FAULT (regardless of d2)
  - d1 & !d2 -> ONE
REQ-024 In FAULT, the FSM SHALL go to IDLE when !d1 & !d2 and SHALL otherwise remain in FAULT.
REQ-025 SHALL set fault on every entry to FAULT; fault SHALL clear only on reset.
REQ-026 SHALL register status and checkbits in the same edge as the state update, so both change together with no intermediate value.
REQ-027 SHALL drive outputs per state:
  - IDLE: status 2'b00, checkbits 4'h0
  - ONE: status 2'b01, checkbits CODE_ONE
  - BOTH: status 2'b11, checkbits CODE_BOTH
  - FAULT: status {d2,d1}, checkbits 4'hF
REQ-028 SHALL update the state on the edge after the debounced-level change; the total delay from a raw edge to the status change SHALL be 3+DEBOUNCE_CYCLES edges, with +1 edge allowed for asynchronous sampling.
REQ-029 SHALL push the new-state code into a 4-entry FIFO on every state transition; at most one push per cycle.
REQ-030 SHALL drive evt_valid = FIFO non-empty and evt_code = FIFO head; the pop SHALL occur on an edge with evt_valid & evt_ack.
REQ-031 SHALL ignore evt_ack while evt_valid = 0.
REQ-032 When the FIFO is full with a push and no pop, SHALL drop the new event and set evt_overflow (sticky until reset).
REQ-033 When the FIFO is full with a simultaneous push and pop, SHALL perform both with no overflow.
REQ-034 SHALL wrap the read and write pointers modulo 4 and track occupancy with a 3-bit count.

Reset
REQ-035 With resetb = 0 at an edge, SHALL set the synchronizers, debounced levels and counters to 0.
REQ-036 With resetb = 0 at an edge, SHALL set state to IDLE, status 2'b00, checkbits 4'h0, FIFO empty (evt_valid 0, evt_code 3'd0), fault 0 and evt_overflow 0.
REQ-037 Reset asserted mid-operation SHALL abandon any pending debounce and discard FIFO contents, with no event pushed for the reset itself.

Verification
REQ-038 Bench SHALL cover: por1_raw rise, then por2_raw rise 200 cycles later, DEBOUNCE_CYCLES=16 -> status 01 with checkbits 9 at 19-20 edges after the first rise; status 11 with checkbits 5 at 19-20 edges after the second; events 1 then 2.
REQ-039 Bench SHALL cover: a 10-cycle por1_raw glitch -> status stays 00, evt_valid stays 0.
REQ-040 Bench SHALL cover: por2_raw high with por1_raw low -> FAULT, checkbits F, fault 1, event 3; both low -> IDLE with fault still 1.
REQ-041 Bench SHALL cover: 5 transitions with evt_ack held 0 -> first 4 codes retained in order, evt_overflow 1; then full with push and ack in the same cycle -> no overflow, order preserved.
REQ-042 Bench SHALL cover: from BOTH, por1_raw falls -> FAULT with checkbits F and status {d2,d1} = 10.
REQ-043 Bench SHALL cover: resetb low for 1 cycle while in BOTH with 2 events queued -> status 00, checkbits 0, evt_valid 0, fault 0 on the next edge.
